// File: rtl/cphy_tx_pkg.sv
// Shared types, constants and the 16-bit to 7-symbol C-PHY mapping for the TX symbol stream.
// Optional sync-word support is compiled in with CPHY_TX_SYNC_EN.
package cphy_tx_pkg;

  localparam int unsigned CPHY_SYM_W    = 3;
  localparam int unsigned SYMS_PER_WORD = 7;

  typedef logic [CPHY_SYM_W-1:0] cphy_sym_t;
  typedef cphy_sym_t [SYMS_PER_WORD-1:0] cphy_syms_t;

  localparam cphy_sym_t SYM_SYNC_3 = 3'd3;
  localparam cphy_sym_t SYM_SYNC_4 = 3'd4;
  localparam cphy_sym_t SYM_FLIP   = 3'b100;

`ifdef CPHY_TX_SYNC_EN
  localparam cphy_syms_t SYNC_WORD = {SYM_SYNC_3, {5{SYM_SYNC_4}}, SYM_SYNC_3};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
`ifdef CPHY_TX_SYNC_EN
    , ST_SYNC = 2'd2
`endif
  } cphy_tx_state_e;

  // Top nibble selects the flip positions; the remaining low bit pairs fill {R,P} of the
  // non-flip symbols from s0 upward.
  function automatic cphy_syms_t cphy_map16(input logic [15:0] word);
    cphy_syms_t  syms;
    logic [6:0]  flip;
    logic [3:0]  k;
    logic [13:0] rp;
    syms = '0;
    flip = '0;
    rp   = word[13:0];
    k    = word[15:12] - 4'd4;
    if (word[15:14] != 2'b00) begin
      if (k < 4'd7) begin
        flip[k[2:0]] = 1'b1;
        rp           = {2'b00, word[11:0]};
      end else begin
        flip[6]               = 1'b1;
        flip[3'(k - 4'd7)]    = 1'b1;
        rp                    = {4'b0000, word[9:0]};
      end
    end
    for (int unsigned i = 0; i < SYMS_PER_WORD; i++) begin
      if (flip[i]) begin
        syms[i] = SYM_FLIP;
      end else begin
        syms[i] = {1'b0, rp[1:0]};
        rp      = rp >> 2;
      end
    end
    return syms;
  endfunction

endpackage

// File: rtl/cphy_tx_symbol_stream_if.sv
// Word-in / symbol-out handshake bundle between the word packer, the mapper and the lane encoders.
interface cphy_tx_symbol_stream_if #(
  parameter int unsigned LANES = 1,
  parameter int unsigned SYM_W = 3
);
  logic [16*LANES-1:0]    TxData;
  logic                   TxValid;
  logic                   TxReady;
  logic [SYM_W*LANES-1:0] TxSymbol;
  logic                   TxSymValid;
  logic                   TxSymReady;
  logic                   TxWordStart;
  logic                   SyncReq;

  modport master (
    output TxData, TxValid, TxSymReady, SyncReq,
    input  TxReady, TxSymbol, TxSymValid, TxWordStart
  );

  modport slave (
    input  TxData, TxValid, TxSymReady, SyncReq,
    output TxReady, TxSymbol, TxSymValid, TxWordStart
  );
endinterface

// File: rtl/cphy_lane_symreg.sv
// Per-lane 7-symbol holding register: parallel load of a mapped word, shift toward s6 per beat.
module cphy_lane_symreg
  import cphy_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  cphy_syms_t load_data,
  output cphy_sym_t  sym
);

  cphy_syms_t sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      sreg <= {sreg[SYMS_PER_WORD-2:0], cphy_sym_t'(0)};
    end
  end

  assign sym = sreg[SYMS_PER_WORD-1];

endmodule

// File: rtl/cphy_tx_symbol_stream.sv
// Registered C-PHY 16-bit word to 7-symbol streamer, LANES trios in lockstep.
// Define CPHY_TX_SYNC_EN to enable sync-word insertion on SyncReq.
module cphy_tx_symbol_stream
  import cphy_tx_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned SYM_W = CPHY_SYM_W
) (
  input logic                   clk,
  input logic                   rst_n,
  cphy_tx_symbol_stream_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  cphy_tx_state_e               state, state_n;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic                         sym_valid, sym_valid_n;
  logic                         word_start, word_start_n;
  logic                         beat_c, last_c, sample_c, sync_take_c, ready_c;
  logic                         load_c, shift_c;
  logic [LANES-1:0][SYM_W-1:0]  lane_sym;
`ifdef CPHY_TX_SYNC_EN
  logic                         load_sync_c;
`else
  logic                         unused_sync_req;
  assign unused_sync_req = bus.SyncReq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sym_valid  <= 1'b0;
      word_start <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sym_valid  <= sym_valid_n;
      word_start <= word_start_n;
    end
  end

  // A new word (or sync word) is taken in IDLE or on the last beat, so words stream without bubbles.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sym_valid_n  = sym_valid;
    word_start_n = word_start;
    load_c       = 1'b0;
    shift_c      = 1'b0;
    sync_take_c  = 1'b0;
`ifdef CPHY_TX_SYNC_EN
    load_sync_c  = 1'b0;
`endif
    beat_c       = sym_valid && bus.TxSymReady;
    last_c       = beat_c && (cnt == '0);
    sample_c     = (state == ST_IDLE) || last_c;
`ifdef CPHY_TX_SYNC_EN
    sync_take_c  = rst_n && sample_c && bus.SyncReq;
`endif
    ready_c      = rst_n && sample_c && !sync_take_c;

    if (sync_take_c || (ready_c && bus.TxValid)) begin
      load_c       = 1'b1;
      state_n      = ST_SEND;
`ifdef CPHY_TX_SYNC_EN
      load_sync_c  = sync_take_c;
      if (sync_take_c) state_n = ST_SYNC;
`endif
      cnt_n        = CNT_W'(SYMS_PER_WORD - 1);
      sym_valid_n  = 1'b1;
      word_start_n = 1'b1;
    end else if (last_c) begin
      state_n      = ST_IDLE;
      sym_valid_n  = 1'b0;
      word_start_n = 1'b0;
    end else if (beat_c) begin
      cnt_n        = cnt - CNT_W'(1);
      shift_c      = 1'b1;
      word_start_n = 1'b0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cphy_syms_t load_data;
`ifdef CPHY_TX_SYNC_EN
    assign load_data = load_sync_c ? SYNC_WORD : cphy_map16(bus.TxData[16*k +: 16]);
`else
    assign load_data = cphy_map16(bus.TxData[16*k +: 16]);
`endif
    cphy_lane_symreg u_symreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_c),
      .shift     (shift_c),
      .load_data (load_data),
      .sym       (lane_sym[k])
    );
  end

  assign bus.TxReady     = ready_c;
  assign bus.TxSymValid  = sym_valid;
  assign bus.TxWordStart = word_start;
  assign bus.TxSymbol    = lane_sym;

endmodule

// File: tb/tb_cphy_tx_symbol_stream.sv
// Bench for cphy_tx_symbol_stream: vector table, corner sequences and a random run against a beat-queue model.
module tb_cphy_tx_symbol_stream;

  localparam int LANES = 3;

  typedef struct packed {
    logic [3*LANES-1:0] sym;
    logic               ws;
  } beat_t;

  typedef struct packed {
    logic [3*LANES-1:0] sym;
    logic               ws;
    logic [31:0]        cyc;
  } cap_t;

  typedef struct {
    logic [16*LANES-1:0] words;
    logic [21*LANES-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cphy_tx_symbol_stream_if #(.LANES(LANES), .SYM_W(3)) bus ();

  cphy_tx_symbol_stream #(.LANES(LANES), .SYM_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  bit    acc_seen;
  beat_t exp_q[$];
  cap_t  cap_q[$];
  vec_t  vecs[4];

  function void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Symbol sequence of one word, s6 in the top octal digit.
  function automatic logic [20:0] model_map(input logic [15:0] w);
    int          code, k, rp;
    logic [6:0]  fl;
    logic [20:0] r;
    code = int'(w) / 4096;
    rp   = int'(w) % 16384;
    fl   = '0;
    r    = '0;
    if (code >= 4) begin
      k = code - 4;
      if (k < 7) begin
        fl[k] = 1'b1;
        rp    = int'(w) % 4096;
      end else begin
        fl[6]     = 1'b1;
        fl[k - 7] = 1'b1;
        rp        = int'(w) % 1024;
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (fl[i]) r[3*i +: 3] = 3'd4;
      else begin
        r[3*i +: 3] = 3'(rp % 4);
        rp = rp / 4;
      end
    end
    return r;
  endfunction

  function void push_words(input logic [16*LANES-1:0] words, input bit sync);
    logic [20:0] seq [LANES];
    beat_t       b;
    for (int l = 0; l < LANES; l++)
      seq[l] = sync ? 21'o3444443 : model_map(words[16*l +: 16]);
    for (int s = 6; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) b.sym[3*l +: 3] = seq[l][3*s +: 3];
      b.ws = (s == 6);
      exp_q.push_back(b);
    end
  endfunction

  // Model: the outstanding beats form a queue; a word is taken whenever at most the final beat remains.
  function void model_step();
    bit   samp, syn, exp_ready;
    cap_t c;
    acc_seen = 1'b0;
    if (!rst_n) begin
      check("rst_valid", 64'(bus.TxSymValid), 64'd0);
      check("rst_ready", 64'(bus.TxReady), 64'd0);
      exp_q.delete();
      return;
    end
    samp = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.TxSymReady);
    syn  = 1'b0;
`ifdef CPHY_TX_SYNC_EN
    syn  = samp && bus.SyncReq;
`endif
    exp_ready = samp && !syn;
    check("ready", 64'(bus.TxReady), 64'(exp_ready));
    check("valid", 64'(bus.TxSymValid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("symbol", 64'(bus.TxSymbol), 64'(exp_q[0].sym));
      check("wstart", 64'(bus.TxWordStart), 64'(exp_q[0].ws));
      if (bus.TxSymReady) begin
        c.sym = bus.TxSymbol;
        c.ws  = bus.TxWordStart;
        c.cyc = 32'(cyc);
        cap_q.push_back(c);
        void'(exp_q.pop_front());
      end
    end
    if (syn) push_words('0, 1'b1);
    else if (exp_ready && bus.TxValid) begin
      push_words(bus.TxData, 1'b0);
      acc_seen = 1'b1;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!acc_seen && n < 30);
    check({name, "_accept"}, 64'(acc_seen), 64'd1);
  endtask

  function void check_seq(string name, int base, logic [21*LANES-1:0] req);
    logic [20:0] act;
    logic [6:0]  ws;
    check({name, "_count"}, 64'(cap_q.size() >= base + 7), 64'd1);
    if (cap_q.size() < base + 7) return;
    for (int l = 0; l < LANES; l++) begin
      act = '0;
      for (int j = 0; j < 7; j++) act[3*(6-j) +: 3] = cap_q[base+j].sym[3*l +: 3];
      check($sformatf("%s_lane%0d", name, l), 64'(act), 64'(req[21*l +: 21]));
    end
    ws = '0;
    for (int j = 0; j < 7; j++) ws[6-j] = cap_q[base+j].ws;
    check({name, "_wstart"}, 64'(ws), 64'(7'b1000000));
  endfunction

  task automatic send_word(string name, input logic [16*LANES-1:0] words);
    bus.TxData  = words;
    bus.TxValid = 1'b1;
    wait_accept(name);
    bus.TxValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{{16'h000F, 16'h6025, 16'h000F}, {21'o0000033, 21'o0002411, 21'o0000033}};
    vecs[1] = '{{16'h912A, 16'h0000, 16'h6025}, {21'o0410222, 21'o0000000, 21'o0002411}};
    vecs[2] = '{{16'hFFFF, 16'h3FFF, 16'h4000}, {21'o4343333, 21'o3333333, 21'o0000004}};
    vecs[3] = '{{16'hB000, 16'hA555, 16'h8003}, {21'o4000004, 21'o4111111, 21'o0040003}};

    bus.TxData     = '0;
    bus.TxValid    = 1'b0;
    bus.TxSymReady = 1'b1;
    bus.SyncReq    = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_symbol", 64'(bus.TxSymbol), 64'd0);
    check("rst_wstart", 64'(bus.TxWordStart), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.TxReady), 64'd1);
    tick();

    // Vector table, one word per lane, downstream always ready
    for (int v = 0; v < 4; v++) begin
      cap_q.delete();
      send_word($sformatf("vec%0d", v), vecs[v].words);
      repeat (8) tick();
      check_seq($sformatf("vec%0d", v), 0, vecs[v].exp);
    end

    // Back-to-back words with TxValid held: 14 contiguous beats
    cap_q.delete();
    bus.TxData  = {3{16'h6025}};
    bus.TxValid = 1'b1;
    wait_accept("b2b_first");
    bus.TxData  = {3{16'h912A}};
    wait_accept("b2b_second");
    bus.TxData  = {3{16'hFFFF}};
    bus.TxValid = 1'b0;
    repeat (9) tick();
    check_seq("b2b_w0", 0, {3{21'o0002411}});
    check_seq("b2b_w1", 7, {3{21'o0410222}});
    check("b2b_beats", 64'(cap_q.size()), 64'd14);
    if (cap_q.size() == 14) check("b2b_gap", 64'(cap_q[13].cyc - cap_q[0].cyc), 64'd13);

    // Downstream stall after beat 3
    cap_q.delete();
    send_word("stall", {16'h000F, 16'h6025, 16'h912A});
    repeat (3) tick();
    bus.TxSymReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_symbol", 64'(bus.TxSymbol), 64'({3'd0, 3'd2, 3'd0}));
      check("stall_valid", 64'(bus.TxSymValid), 64'd1);
      check("stall_ready", 64'(bus.TxReady), 64'd0);
      check("stall_wstart", 64'(bus.TxWordStart), 64'd0);
    end
    bus.TxSymReady = 1'b1;
    repeat (5) tick();
    check_seq("stall", 0, {21'o0000033, 21'o0002411, 21'o0410222});

    // Reset during beat 4
    send_word("rst_mid", {3{16'h6025}});
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(bus.TxSymValid), 64'd0);
    check("rst_mid_symbol", 64'(bus.TxSymbol), 64'd0);
    check("rst_mid_ready", 64'(bus.TxReady), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 64'(bus.TxReady), 64'd1);
    cap_q.delete();
    send_word("after_rst", {3{16'h000F}});
    repeat (8) tick();
    check_seq("after_rst", 0, {3{21'o0000033}});

`ifdef CPHY_TX_SYNC_EN
    // Sync request wins over a pending word in IDLE
    cap_q.delete();
    bus.TxData  = {3{16'h000F}};
    bus.TxValid = 1'b1;
    bus.SyncReq = 1'b1;
    tick();
    bus.SyncReq = 1'b0;
    wait_accept("sync");
    bus.TxValid = 1'b0;
    repeat (9) tick();
    check_seq("sync_word", 0, {3{21'o3444443}});
    check_seq("sync_data", 7, {3{21'o0000033}});
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.TxValid    = ($urandom_range(0, 3) != 0);
      bus.TxData     = {$urandom, $urandom};
      bus.TxSymReady = ($urandom_range(0, 3) != 0);
`ifdef CPHY_TX_SYNC_EN
      bus.SyncReq    = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    bus.TxValid    = 1'b0;
    bus.TxSymReady = 1'b1;
    bus.SyncReq    = 1'b0;
    repeat (20) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(bus.TxSymValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
